frame_uart_dumper: RTL
======================

Name: frame_uart_dumper

Overview:
- Parametrised successor to the fixed 40x30x4-byte button-triggered UART frame dump sequencer.
- Walks a downsampled frame buffer (x, y, byte lane) through its synchronous read port and serialises every byte into the byte-wide UART transmitter, with inter-byte holdoff.
- Adds over the previous generation: generic geometry and word width, configurable read latency, framed header, continuous mode, abort, status outputs.
- Sits in the read-clock domain (12 MHz) between the downsample buffer and the uart block.

Parameters:
- WIDTH, 40, words per row (1..255).
- HEIGHT, 30, rows per frame (1..255).
- BYTES_PER_WORD, 4, bytes in one rd_data word, sent MSB byte first (1..8).
- RD_LAT, 1, cycles from rd_x/rd_y change to valid rd_data (1..3).
- HOLDOFF_BITS, 13, holdoff counter width; next byte only after counter saturates at 2^HOLDOFF_BITS-1.
- DEB_BITS, 14, trigger debounce counter width.

Ports:
- sys_clk_i  in  1  system clock, 12 MHz.
- areset  in  1  reset, asynchronous, active-high.
- trigger_i  in  1  raw button, high = pressed, asynchronous.
- continuous_i  in  1  level; when high, frames repeat back to back.
- abort_i  in  1  level; stops the dump.
- rd_x  out  $clog2(WIDTH)  buffer column address.
- rd_y  out  $clog2(HEIGHT)  buffer row address.
- rd_data  in  8*BYTES_PER_WORD  buffer read data.
- uart_wr_o  out  1  one-cycle write strobe.
- uart_dat_o  out  8  byte, valid while uart_wr_o is high.
- uart_busy_i  in  1  uart transmitting.
- busy_o  out  1  high in any state except IDLE.
- frame_done_o  out  1  one-cycle pulse after the last byte of a frame is written.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters 0.
- Trigger synchroniser: 2 flops.
- Debounce counter:
  - cleared while the synced trigger is low;
  - increments while high, saturating;
  - `fire` = one pulse on the cycle it saturates; rearms only after release.
  - Fire outside IDLE is ignored.
- Holdoff counter:
  - cleared on any cycle with uart_busy_i=1 or uart_wr_o=1;
  - otherwise increments, saturating.
  - `ready` = holdoff saturated && !uart_busy_i && !uart_wr_o.
- FSM states: IDLE, HDR, FETCH, SEND, NEXT, TRAIL, DONE.
- IDLE: on fire, x=y=lane=0, hdr_idx=0, go HDR.
- HDR:
  - on ready, emit header byte hdr_idx, in order 0xA5, 0x5A, WIDTH[7:0], HEIGHT[7:0];
  - after byte 3, go FETCH.
- FETCH:
  - wait RD_LAT cycles after entry;
  - latch rd_data into a shift register; go SEND.
- SEND:
  - on ready, emit shift[MSB byte]; shift left 8; lane++;
  - if lane==BYTES_PER_WORD-1, go NEXT; else stay.
- NEXT:
  - if x==WIDTH-1: x=0, then y==HEIGHT-1 ? go TRAIL : (y++, go FETCH);
  - else x++, go FETCH.
- TRAIL: go DONE immediately (see optional feature).
- DONE:
  - pulse frame_done_o;
  - if continuous_i, reset indices and go HDR; else go IDLE.
- rd_x/rd_y are registered and change only in NEXT/IDLE, so they are stable throughout FETCH.
- Byte count per frame = 4 + WIDTH*HEIGHT*BYTES_PER_WORD; no byte is skipped or repeated.
- Abort:
  - abort_i sampled in any non-IDLE state;
  - no further uart_wr_o after the current cycle;
  - go IDLE with no frame_done_o;
  - a write asserted in the same cycle completes normally.
- Simultaneous abort and DONE: abort wins, so no pulse and no restart.
- Areset mid-frame: immediate return to IDLE; uart_wr_o drops asynchronously.

Optional Feature:
- Macro FRAME_UART_DUMPER_CHECKSUM_EN.
- Defined:
  - an 8-bit running sum (mod 256) of all payload bytes (header excluded) is kept;
  - cleared at HDR entry;
  - TRAIL waits for ready, then emits the sum as one extra byte before DONE;
  - frame length = 5 + WIDTH*HEIGHT*BYTES_PER_WORD.
- Undefined: no sum register; TRAIL passes straight to DONE.

Decomposition:
- Package frame_uart_dumper_pkg holds:
  - state enum;
  - SYNC0=8'hA5, SYNC1=8'h5A;
  - HDR_LEN=4.
- Sub-module frame_uart_dumper_debounce (synchroniser + debounce + one-shot, parameter DEB_BITS) is natural; it is reused for the other buttons.

Test Plan:
- Reset/idle: areset held, then released, with trigger low -> all outputs 0, no uart_wr_o for 10k cycles.
- Full frame:
  - setup: WIDTH=4, HEIGHT=2, BYTES_PER_WORD=4, HOLDOFF_BITS=4; rd_data = {y,x,8'hC3,8'h3C}; uart model with busy 20 cycles per byte.
  - stimulus: press trigger 2^DEB_BITS+4 cycles.
  - response: bytes A5 5A 04 02 then 00 00 C3 3C 00 01 C3 3C ... 01 03 C3 3C; 36 writes; one frame_done_o.
- Read latency: RD_LAT=3 with a 3-stage delayed memory model -> identical byte stream to RD_LAT=1.
- Continuous mode:
  - continuous_i=1 -> two frames back to back, header present in each, frame_done_o twice.
  - deassert continuous_i mid-frame-2 -> IDLE after frame 2.
- Abort: assert abort_i after the 10th byte -> at most 10 writes, busy_o low within 2 cycles, no frame_done_o; a new trigger then restarts with A5.
- Checksum (macro on): all payload bytes 0x01, 32 bytes -> trailer byte 0x20, 37 writes total; macro off -> 36 writes.

Source files
------------

// File: rtl/frame_uart_dumper_pkg.sv
// Shared types and constants for the frame UART dumper.
package frame_uart_dumper_pkg;

    // Dumper sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
        ST_NEXT,
        ST_TRAIL,
        ST_DONE
    } state_t;

    // Frame header sync bytes, followed by WIDTH[7:0] and HEIGHT[7:0].
    localparam logic [7:0] SYNC0   = 8'hA5;
    localparam logic [7:0] SYNC1   = 8'h5A;
    localparam int         HDR_LEN = 4;

    // Address width for a range of n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_uart_dumper_if.sv
// Buffer read port and UART byte port between the dumper and its neighbours.
//
// Handshake: rd_x/rd_y address the buffer and rd_data follows a fixed number
// of cycles later (no valid/ready). On the UART side uart_wr_o is a one-cycle
// strobe that qualifies uart_dat_o; the master raises it only while
// uart_busy_i is low, so uart_busy_i acts as the inverse of ready and a byte
// is transferred on every cycle uart_wr_o is high.
interface frame_uart_dumper_if #(
    parameter int X_W    = 6,
    parameter int Y_W    = 5,
    parameter int DATA_W = 32
);
    logic [X_W-1:0]    rd_x;
    logic [Y_W-1:0]    rd_y;
    logic [DATA_W-1:0] rd_data;
    logic              uart_wr_o;
    logic [7:0]        uart_dat_o;
    logic              uart_busy_i;

    // The dumper side.
    modport master (
        output rd_x, rd_y, uart_wr_o, uart_dat_o,
        input  rd_data, uart_busy_i
    );

    // The frame buffer / UART side.
    modport slave (
        input  rd_x, rd_y, uart_wr_o, uart_dat_o,
        output rd_data, uart_busy_i
    );
endinterface

// File: rtl/frame_uart_dumper_debounce.sv
// Button conditioner: two-flop synchroniser, saturating debounce counter and
// a one-shot fire pulse that rearms only after the button is released.
module frame_uart_dumper_debounce #(
    parameter int DEB_BITS = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic fire_o
);
    localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

    logic [1:0]          sync_q;
    logic [DEB_BITS-1:0] cnt_q;
    logic                fire_q;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], btn_i};
    end

    // Count while pressed, hold at saturation, clear on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt_q <= '0;
        else if (!sync_q[1])     cnt_q <= '0;
        else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end

    // Single pulse when the counter reaches saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fire_q <= 1'b0;
        else     fire_q <= sync_q[1] && (cnt_q == CNT_MAX - 1'b1);
    end

    assign fire_o = fire_q;
endmodule

// File: rtl/frame_uart_dumper.sv
// Frame UART dumper: on a debounced trigger, sends a 4-byte header then every
// byte of a WIDTH x HEIGHT frame buffer (MSB byte of each word first) to the
// UART, spacing bytes by a holdoff counter. Supports continuous repeat, abort
// and status outputs.
// Optional: define FRAME_UART_DUMPER_CHECKSUM_EN to append an 8-bit payload
// sum as a trailer byte after the last pixel byte.
module frame_uart_dumper
    import frame_uart_dumper_pkg::*;
#(
    parameter int WIDTH          = 40,
    parameter int HEIGHT         = 30,
    parameter int BYTES_PER_WORD = 4,
    parameter int RD_LAT         = 1,
    parameter int HOLDOFF_BITS   = 13,
    parameter int DEB_BITS       = 14
) (
    input  logic                 sys_clk_i,
    input  logic                 areset,
    input  logic                 trigger_i,
    input  logic                 continuous_i,
    input  logic                 abort_i,
    frame_uart_dumper_if.master  bus,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output state_t               dbg_state
);
    localparam int X_W    = addr_w(WIDTH);
    localparam int Y_W    = addr_w(HEIGHT);
    localparam int LANE_W = addr_w(BYTES_PER_WORD);
    localparam int HDR_W  = addr_w(HDR_LEN);
    localparam int DATA_W = 8 * BYTES_PER_WORD;

    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'(HDR_LEN - 1);

    state_t                  state, state_n;
    logic [X_W-1:0]          x_q;
    logic [Y_W-1:0]          y_q;
    logic [LANE_W-1:0]       lane_q;
    logic [HDR_W-1:0]        hdr_idx_q;
    logic [1:0]              wait_q;
    logic [DATA_W-1:0]       shift_q;
    logic [HOLDOFF_BITS-1:0] holdoff_q;
    logic                    wr_q, done_q;
    logic [7:0]              dat_q;

    logic       fire, ready;
    logic       emit, start_frame, hdr_step, load_word, byte_step;
    logic       col_step, row_step, done_evt;
    logic [7:0] emit_dat, hdr_byte;

`ifdef FRAME_UART_DUMPER_CHECKSUM_EN
    logic [7:0] sum_q;
`endif

    frame_uart_dumper_debounce #(.DEB_BITS(DEB_BITS)) u_debounce (
        .clk    (sys_clk_i),
        .rst    (areset),
        .btn_i  (trigger_i),
        .fire_o (fire)
    );

    // Inter-byte spacing: restart whenever the UART is busy or being written.
    always_ff @(posedge sys_clk_i or posedge areset) begin
        if (areset)                          holdoff_q <= '0;
        else if (bus.uart_busy_i || wr_q)    holdoff_q <= '0;
        else if (!(&holdoff_q))              holdoff_q <= holdoff_q + 1'b1;
    end

    assign ready = (&holdoff_q) && !bus.uart_busy_i && !wr_q;

    // Header byte selected by its index.
    always_comb begin
        case (hdr_idx_q)
            HDR_W'(0): hdr_byte = SYNC0;
            HDR_W'(1): hdr_byte = SYNC1;
            HDR_W'(2): hdr_byte = 8'(WIDTH);
            default:   hdr_byte = 8'(HEIGHT);
        endcase
    end

    // Next-state and datapath strobes; abort overrides every state but IDLE.
    always_comb begin
        state_n     = state;
        emit        = 1'b0;
        emit_dat    = 8'h00;
        start_frame = 1'b0;
        hdr_step    = 1'b0;
        load_word   = 1'b0;
        byte_step   = 1'b0;
        col_step    = 1'b0;
        row_step    = 1'b0;
        done_evt    = 1'b0;
        if (abort_i && state != ST_IDLE) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (fire) begin
                    start_frame = 1'b1;
                    state_n     = ST_HDR;
                end
                ST_HDR: if (ready) begin
                    emit     = 1'b1;
                    emit_dat = hdr_byte;
                    hdr_step = 1'b1;
                    if (hdr_idx_q == HDR_LAST) state_n = ST_FETCH;
                end
                ST_FETCH: if (wait_q == 2'(RD_LAT)) begin
                    load_word = 1'b1;
                    state_n   = ST_SEND;
                end
                ST_SEND: if (ready) begin
                    emit      = 1'b1;
                    emit_dat  = shift_q[DATA_W-1 -: 8];
                    byte_step = 1'b1;
                    if (lane_q == LANE_LAST) state_n = ST_NEXT;
                end
                ST_NEXT: begin
                    col_step = 1'b1;
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_n = ST_TRAIL;
                    end else begin
                        row_step = (x_q == X_LAST);
                        state_n  = ST_FETCH;
                    end
                end
`ifdef FRAME_UART_DUMPER_CHECKSUM_EN
                ST_TRAIL: if (ready) begin
                    emit     = 1'b1;
                    emit_dat = sum_q;
                    state_n  = ST_DONE;
                end
`else
                ST_TRAIL: state_n = ST_DONE;
`endif
                ST_DONE: begin
                    done_evt = 1'b1;
                    if (continuous_i) begin
                        start_frame = 1'b1;
                        state_n     = ST_HDR;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State register, frame indices, word shifter and registered UART outputs.
    always_ff @(posedge sys_clk_i or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            lane_q    <= '0;
            hdr_idx_q <= '0;
            wait_q    <= '0;
            shift_q   <= '0;
            wr_q      <= 1'b0;
            dat_q     <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state  <= state_n;
            wr_q   <= emit;
            done_q <= done_evt;
            if (emit) dat_q <= emit_dat;
            if (start_frame) begin
                x_q       <= '0;
                y_q       <= '0;
                lane_q    <= '0;
                hdr_idx_q <= '0;
            end
            if (hdr_step) hdr_idx_q <= hdr_idx_q + 1'b1;
            if (state_n == ST_FETCH && state != ST_FETCH) wait_q <= '0;
            else if (state == ST_FETCH)                   wait_q <= wait_q + 1'b1;
            if (load_word) shift_q <= bus.rd_data;
            if (byte_step) begin
                shift_q <= shift_q << 8;
                lane_q  <= (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
            end
            if (col_step) x_q <= (x_q == X_LAST) ? '0 : x_q + 1'b1;
            if (row_step) y_q <= y_q + 1'b1;
        end
    end

`ifdef FRAME_UART_DUMPER_CHECKSUM_EN
    // Running mod-256 sum of payload bytes, restarted with each frame.
    always_ff @(posedge sys_clk_i or posedge areset) begin
        if (areset)           sum_q <= 8'h00;
        else if (start_frame) sum_q <= 8'h00;
        else if (byte_step)   sum_q <= sum_q + shift_q[DATA_W-1 -: 8];
    end
`endif

    assign bus.rd_x       = x_q;
    assign bus.rd_y       = y_q;
    assign bus.uart_wr_o  = wr_q;
    assign bus.uart_dat_o = dat_q;
    assign busy_o         = (state != ST_IDLE);
    assign frame_done_o   = done_q;
    assign dbg_state      = state;
endmodule
